// File: rtl/atc_cam.sv
// Tag CAM for the MC68851 ATC: parallel lookup, auto-allocating writes, invalidate and flush.
// Define ATC_CAM_MASK_EN to add per-entry compare masks and the wr_mask_i port.
module atc_cam #(
    parameter int TAG_W = 32,
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             lk_valid_i,
    input  logic [TAG_W-1:0] lk_tag_i,
    output logic             lk_valid_o,
    output logic             lk_hit_o,
    output logic [IDX_W-1:0] lk_idx_o,
    input  logic             wr_valid_i,
    input  logic             wr_auto_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
`ifdef ATC_CAM_MASK_EN
    input  logic [TAG_W-1:0] wr_mask_i,
`endif
    output logic             wr_done_o,
    output logic [IDX_W-1:0] wr_slot_o,
    input  logic             inv_valid_i,
    input  logic [TAG_W-1:0] inv_tag_i,
    input  logic             flush_i,
    output logic [DEPTH-1:0] valid_o
);

    logic [TAG_W-1:0] r_tag [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_victim;
    logic             r_lk_valid;
    logic             r_lk_hit;
    logic [IDX_W-1:0] r_lk_idx;
    logic             r_wr_done;
    logic [IDX_W-1:0] r_wr_slot;

    logic [TAG_W-1:0] w_mask [DEPTH];
    logic [DEPTH-1:0] w_lk_match;
    logic [DEPTH-1:0] w_wr_match;
    logic [DEPTH-1:0] w_inv_match;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_lk_idx;
    logic             w_dup_hit;
    logic [IDX_W-1:0] w_dup_idx;
    logic             w_free_hit;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_idx_ok;
    logic             w_wr_go;
    logic             w_use_victim;
    logic [IDX_W-1:0] w_wr_slot;
    logic [IDX_W-1:0] w_victim_next;

`ifdef ATC_CAM_MASK_EN
    logic [TAG_W-1:0] r_mask [DEPTH];

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_mask[e] = r_mask[e];
        end
    end
`else
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_mask[e] = '1;
        end
    end
`endif

    // Lowest set bit wins; MSB of the result is the "any set" flag.
    function automatic logic [IDX_W:0] f_first(input logic [DEPTH-1:0] v);
        logic [IDX_W:0] res;
        res = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (v[e]) begin
                res = {1'b1, IDX_W'(e)};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_lk_match[e]  = r_valid[e] && (((r_tag[e] ^ lk_tag_i)  & w_mask[e]) == '0);
            w_wr_match[e]  = r_valid[e] && (((r_tag[e] ^ wr_tag_i)  & w_mask[e]) == '0);
            w_inv_match[e] = r_valid[e] && (((r_tag[e] ^ inv_tag_i) & w_mask[e]) == '0);
        end
    end

    assign {w_lk_hit, w_lk_idx}     = f_first(w_lk_match);
    assign {w_dup_hit, w_dup_idx}   = f_first(w_wr_match);
    assign {w_free_hit, w_free_idx} = f_first(~r_valid);

    assign w_idx_ok      = ({1'b0, wr_idx_i} < (IDX_W + 1)'(DEPTH));
    assign w_wr_go       = wr_valid_i && !flush_i && !inv_valid_i && (wr_auto_i || w_idx_ok);
    assign w_use_victim  = wr_auto_i && !w_dup_hit && !w_free_hit;
    assign w_victim_next = (r_victim == IDX_W'(DEPTH - 1)) ? '0 : r_victim + 1'b1;

    always_comb begin
        w_wr_slot = wr_idx_i;
        if (wr_auto_i) begin
            if (w_dup_hit) begin
                w_wr_slot = w_dup_idx;
            end else if (w_free_hit) begin
                w_wr_slot = w_free_idx;
            end else begin
                w_wr_slot = r_victim;
            end
        end
    end

    // Flush beats invalidate beats write; lookups always see pre-update state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid    <= '0;
            r_victim   <= '0;
            r_lk_valid <= 1'b0;
            r_lk_hit   <= 1'b0;
            r_lk_idx   <= '0;
            r_wr_done  <= 1'b0;
            r_wr_slot  <= '0;
        end else begin
            r_lk_valid <= lk_valid_i;
            r_lk_hit   <= lk_valid_i && w_lk_hit;
            r_lk_idx   <= (lk_valid_i && w_lk_hit) ? w_lk_idx : '0;
            r_wr_done  <= w_wr_go;
            r_wr_slot  <= w_wr_go ? w_wr_slot : '0;
            if (flush_i) begin
                r_valid <= '0;
            end else if (inv_valid_i) begin
                r_valid <= r_valid & ~w_inv_match;
            end else if (w_wr_go) begin
                r_valid[w_wr_slot] <= 1'b1;
            end
            if (w_wr_go && w_use_victim) begin
                r_victim <= w_victim_next;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && w_wr_go) begin
            r_tag[w_wr_slot] <= wr_tag_i;
`ifdef ATC_CAM_MASK_EN
            r_mask[w_wr_slot] <= wr_mask_i;
`endif
        end
    end

    assign lk_valid_o = r_lk_valid;
    assign lk_hit_o   = r_lk_hit;
    assign lk_idx_o   = r_lk_idx;
    assign wr_done_o  = r_wr_done;
    assign wr_slot_o  = r_wr_slot;
    assign valid_o    = r_valid;

endmodule

// File: tb/tb_atc_cam.sv
// Self-checking bench for atc_cam: vector table driven cycle by cycle, expectations via a scoreboard queue.
module tb_atc_cam;

    localparam int TAG_W = 32;
    localparam int DEPTH = 32;
    localparam int IDX_W = 5;

    typedef struct {
        logic             rst;
        logic             lkv;
        logic [TAG_W-1:0] lkt;
        logic             wrv;
        logic             wra;
        logic [IDX_W-1:0] wri;
        logic [TAG_W-1:0] wrt;
        logic [TAG_W-1:0] wrm;
        logic             inv;
        logic [TAG_W-1:0] invt;
        logic             fl;
        logic             eLkv;
        logic             eHit;
        logic [IDX_W-1:0] eIdx;
        logic             eDone;
        logic [IDX_W-1:0] eSlot;
        logic             chkV;
        logic [DEPTH-1:0] eV;
    } vec_t;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             lk_valid_i;
    logic [TAG_W-1:0] lk_tag_i;
    logic             lk_valid_o;
    logic             lk_hit_o;
    logic [IDX_W-1:0] lk_idx_o;
    logic             wr_valid_i;
    logic             wr_auto_i;
    logic [IDX_W-1:0] wr_idx_i;
    logic [TAG_W-1:0] wr_tag_i;
    logic [TAG_W-1:0] wr_mask_i;
    logic             wr_done_o;
    logic [IDX_W-1:0] wr_slot_o;
    logic             inv_valid_i;
    logic [TAG_W-1:0] inv_tag_i;
    logic             flush_i;
    logic [DEPTH-1:0] valid_o;

    int   checkCount = 0;
    int   passCount  = 0;
    vec_t expQ [$];
    vec_t vecs [$];

    atc_cam #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .lk_valid_i  (lk_valid_i),
        .lk_tag_i    (lk_tag_i),
        .lk_valid_o  (lk_valid_o),
        .lk_hit_o    (lk_hit_o),
        .lk_idx_o    (lk_idx_o),
        .wr_valid_i  (wr_valid_i),
        .wr_auto_i   (wr_auto_i),
        .wr_idx_i    (wr_idx_i),
        .wr_tag_i    (wr_tag_i),
`ifdef ATC_CAM_MASK_EN
        .wr_mask_i   (wr_mask_i),
`endif
        .wr_done_o   (wr_done_o),
        .wr_slot_o   (wr_slot_o),
        .inv_valid_i (inv_valid_i),
        .inv_tag_i   (inv_tag_i),
        .flush_i     (flush_i),
        .valid_o     (valid_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t vIdle();
        vec_t v;
        v.rst = 1'b1; v.lkv = 1'b0; v.lkt = '0; v.wrv = 1'b0; v.wra = 1'b0; v.wri = '0;
        v.wrt = '0; v.wrm = '1; v.inv = 1'b0; v.invt = '0; v.fl = 1'b0;
        v.eLkv = 1'b0; v.eHit = 1'b0; v.eIdx = '0; v.eDone = 1'b0; v.eSlot = '0;
        v.chkV = 1'b0; v.eV = '0;
        return v;
    endfunction

    function automatic vec_t vLk(input logic [TAG_W-1:0] tag, input logic hit, input int idx);
        vec_t v = vIdle();
        v.lkv = 1'b1; v.lkt = tag; v.eLkv = 1'b1; v.eHit = hit; v.eIdx = IDX_W'(idx);
        return v;
    endfunction

    function automatic vec_t vAw(input logic [TAG_W-1:0] tag, input logic done, input int slot);
        vec_t v = vIdle();
        v.wrv = 1'b1; v.wra = 1'b1; v.wrt = tag; v.eDone = done; v.eSlot = IDX_W'(slot);
        return v;
    endfunction

    function automatic vec_t vEw(input int idx, input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] mask);
        vec_t v = vIdle();
        v.wrv = 1'b1; v.wra = 1'b0; v.wri = IDX_W'(idx); v.wrt = tag; v.wrm = mask;
        v.eDone = 1'b1; v.eSlot = IDX_W'(idx);
        return v;
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        vec_t e;
        if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = expQ.pop_front();
            compare("lk_valid_o", 64'(lk_valid_o), 64'(e.eLkv));
            compare("lk_hit_o",   64'(lk_hit_o),   64'(e.eHit));
            compare("lk_idx_o",   64'(lk_idx_o),   64'(e.eIdx));
            compare("wr_done_o",  64'(wr_done_o),  64'(e.eDone));
            if (e.eDone || !e.rst) begin
                compare("wr_slot_o", 64'(wr_slot_o), 64'(e.eSlot));
            end
            if (e.chkV) begin
                compare("valid_o", 64'(valid_o), 64'(e.eV));
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk_i);
        rst_ni      = v.rst;
        lk_valid_i  = v.lkv;
        lk_tag_i    = v.lkt;
        wr_valid_i  = v.wrv;
        wr_auto_i   = v.wra;
        wr_idx_i    = v.wri;
        wr_tag_i    = v.wrt;
        wr_mask_i   = v.wrm;
        inv_valid_i = v.inv;
        inv_tag_i   = v.invt;
        flush_i     = v.fl;
        expQ.push_back(v);
        @(posedge clk_i);
        #1;
        checkOutput();
    endtask

    initial begin
        vec_t v;

        rst_ni = 1'b0; lk_valid_i = 1'b0; lk_tag_i = '0; wr_valid_i = 1'b0; wr_auto_i = 1'b0;
        wr_idx_i = '0; wr_tag_i = '0; wr_mask_i = '1; inv_valid_i = 1'b0; inv_tag_i = '0; flush_i = 1'b0;

        v = vIdle(); v.rst = 1'b0; v.chkV = 1'b1; v.eV = '0;
        vecs.push_back(v);
        vecs.push_back(v);

        for (int i = 0; i < DEPTH; i++) begin
            v = vAw(TAG_W'(32'h100 + i), 1'b1, i);
            if (i == DEPTH - 1) begin
                v.chkV = 1'b1; v.eV = 32'hFFFF_FFFF;
            end
            vecs.push_back(v);
        end
        vecs.push_back(vLk(32'h11F, 1'b1, 31));
        vecs.push_back(vLk(32'h200, 1'b0, 0));

        vecs.push_back(vAw(32'hA0, 1'b1, 0));
        vecs.push_back(vAw(32'hA1, 1'b1, 1));
        vecs.push_back(vLk(32'h100, 1'b0, 0));
        vecs.push_back(vLk(32'hA1, 1'b1, 1));

        v = vIdle(); v.inv = 1'b1; v.invt = 32'h105; v.chkV = 1'b1; v.eV = 32'hFFFF_FFDF;
        vecs.push_back(v);
        vecs.push_back(vAw(32'h105, 1'b1, 5));
        vecs.push_back(vAw(32'h105, 1'b1, 5));
        vecs.push_back(vAw(32'hB0, 1'b1, 2));

        v = vAw(32'hC0, 1'b1, 3); v.lkv = 1'b1; v.lkt = 32'hC0; v.eLkv = 1'b1;
        vecs.push_back(v);
        vecs.push_back(vLk(32'hC0, 1'b1, 3));

        v = vAw(32'hD0, 1'b0, 0); v.fl = 1'b1;
        v.lkv = 1'b1; v.lkt = 32'h104; v.eLkv = 1'b1; v.eHit = 1'b1; v.eIdx = 5'd4;
        v.chkV = 1'b1; v.eV = '0;
        vecs.push_back(v);
        vecs.push_back(vLk(32'h104, 1'b0, 0));

        vecs.push_back(vEw(7, 32'hE7, '1));
        vecs.push_back(vLk(32'hE7, 1'b1, 7));
        vecs.push_back(vAw(32'hE8, 1'b1, 0));
        v = vEw(9, 32'hE8, '1); v.chkV = 1'b1; v.eV = 32'h0000_0281;
        vecs.push_back(v);
        vecs.push_back(vLk(32'hE8, 1'b1, 0));

        v = vAw(32'hF0, 1'b0, 0); v.inv = 1'b1; v.invt = 32'hE7; v.chkV = 1'b1; v.eV = 32'h0000_0201;
        vecs.push_back(v);
        vecs.push_back(vLk(32'hE7, 1'b0, 0));

        v = vAw(32'hF1, 1'b0, 0); v.rst = 1'b0; v.lkv = 1'b1; v.lkt = 32'hE8;
        v.chkV = 1'b1; v.eV = '0;
        vecs.push_back(v);
        vecs.push_back(vLk(32'hE8, 1'b0, 0));
        vecs.push_back(vAw(32'hF2, 1'b1, 0));

`ifdef ATC_CAM_MASK_EN
        vecs.push_back(vEw(2, 32'h1234_5000, 32'hFFFF_F000));
        vecs.push_back(vLk(32'h1234_5ABC, 1'b1, 2));
        vecs.push_back(vLk(32'h1234_6000, 1'b0, 0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        if (expQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard drain: got %0d leftover entries, expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
